// File: rtl/capture_sink_pkg.sv
// -----------------------------------------------------------------------------
// capture_sink_pkg
//   Shared definitions for the capture sink block.
//   - state_t : 2-bit FSM encoding (IDLE, SKIP, CAPTURE, DONE)
//   - clog2   : ceiling log2, used for counter widths
// -----------------------------------------------------------------------------
package capture_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) == 0, clog2(6) == 3.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << res) < 64'(value)) res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
//   Simple dual-port RAM: one synchronous write port, one registered read
//   port. Read-during-write to the same address returns the old contents
//   (the read register samples the array before the write lands). The read
//   register has a synchronous reset to zero; the array itself is never
//   cleared. Written in a style that maps onto FPGA block RAM.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset of the read register only
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address (addresses >= DEPTH return undefined data)
//   o_rdata  : read data, one cycle after i_raddr
// -----------------------------------------------------------------------------
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Separate process from the write so the old value is what gets latched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/capture_sink.sv
// -----------------------------------------------------------------------------
// capture_sink
//   End-of-chain data sink. After start_sink, discards SKIP valid samples
//   (pipeline flush), then stores each valid sample into an internal
//   DEPTH-entry memory. One-shot mode stops when the memory is full;
//   circular mode wraps and keeps overwriting until stop. A free-running
//   registered read port lets the host dump the captured data at any time.
//
//   Handshake: data_in is consumed on every rising edge where data_valid is
//   high; there is no back-pressure, the sink always accepts. start_sink and
//   stop are single-cycle pulses sampled on the rising edge.
//
// Ports
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset (memory not cleared)
//   start_sink  : arms a capture (accepted in IDLE or DONE)
//   stop        : ends a capture early (accepted in SKIP or CAPTURE)
//   data_in     : sample stream
//   data_valid  : qualifies data_in
//   rd_addr     : readback address
//   rd_data     : readback data, 1-cycle latency, old data on collision
//   busy        : high in SKIP or CAPTURE
//   done        : high in DONE
//   wr_count    : samples stored, saturates at DEPTH
//   wrapped     : circular mode: at least one entry has been overwritten
//   o_dbg_state : current FSM state for debug/checkers
// -----------------------------------------------------------------------------
module capture_sink
  import capture_sink_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int SKIP     = 5,
  parameter int CIRCULAR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_sink,
  input  logic              stop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              wrapped,
  output state_t            o_dbg_state
);

  localparam int SKIP_W_RAW = clog2(SKIP + 1);
  localparam int SKIP_W     = (SKIP_W_RAW < 1) ? 1 : SKIP_W_RAW;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
  // Only meaningful when SKIP > 0; the SKIP state is unreachable otherwise.
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP - 1);
  localparam state_t            ARM_STATE = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [SKIP_W-1:0]   r_skip_cnt;
  logic [ADDR_W:0]     r_wr_count;
  logic                r_wrapped;

  logic                w_we;
  logic                w_at_last;

  // Write is suppressed during reset so a mid-capture reset leaves memory
  // exactly as it was.
  assign w_we      = (r_state == ST_CAPTURE) && data_valid && !reset;
  assign w_at_last = (r_wr_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr_addr  <= '0;
      r_skip_cnt <= '0;
      r_wr_count <= '0;
      r_wrapped  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // stop is ignored here, so start always wins a collision.
          if (start_sink) begin
            r_wr_addr  <= '0;
            r_skip_cnt <= '0;
            r_wr_count <= '0;
            r_wrapped  <= 1'b0;
            r_state    <= ARM_STATE;
          end
        end

        ST_SKIP: begin
          if (stop) begin
            r_state <= ST_DONE;
          end else if (data_valid) begin
            r_skip_cnt <= r_skip_cnt + SKIP_ONE;
            if (r_skip_cnt == SKIP_LAST) begin
              r_state <= ST_CAPTURE;
            end
          end
        end

        ST_CAPTURE: begin
          if (data_valid) begin
            // Compare-based wrap so non-power-of-two depths work.
            r_wr_addr <= w_at_last ? '0 : (r_wr_addr + ADDR_ONE);
            if (r_wr_count != CNT_FULL) begin
              r_wr_count <= r_wr_count + CNT_ONE;
            end else begin
              // A full count on a new write means an older entry is being
              // overwritten; only reachable in circular mode.
              r_wrapped <= 1'b1;
            end
            if ((CIRCULAR == 0) && w_at_last) begin
              r_state <= ST_DONE;
            end
          end
          // The sample on the stop cycle has already been written above.
          if (stop) begin
            r_state <= ST_DONE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == ST_SKIP) || (r_state == ST_CAPTURE);
  assign done        = (r_state == ST_DONE);
  assign wr_count    = r_wr_count;
  assign wrapped     = r_wrapped;
  assign o_dbg_state = r_state;

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata (data_in),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

endmodule

// File: doc/capture_sink.md
Name: capture_sink

Overview:
- Parametrised successor to the fixed 256x8 sink capture block.
- Writes a qualified sample stream into an internal simple-dual-port memory, after discarding a programmable number of leading samples (pipeline flush).
- Supports one-shot or circular capture, early stop, sample count and done status, plus an independent read port so the host/test logic can dump captured data.
- Sits at the end of the transmit/receive chain as the data sink.

Parameters:
- DATA_W, 8, sample width in bits
- ADDR_W, 8, memory address width
- DEPTH, 256, number of capture locations; must satisfy 2 <= DEPTH <= 2**ADDR_W
- SKIP, 5, valid samples discarded after start before capture begins; 0 allowed
- CIRCULAR, 0, 0 = stop when full (one-shot); 1 = wrap and keep capturing until stop

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start_sink  in  1  single-cycle pulse; arms a capture
- stop  in  1  single-cycle pulse; ends capture early
- data_in  in  DATA_W  sample stream
- data_valid  in  1  qualifies data_in for the current cycle
- rd_addr  in  ADDR_W  readback address
- rd_data  out  DATA_W  readback data; registered, 1-cycle latency
- busy  out  1  high in SKIP or CAPTURE
- done  out  1  high in DONE
- wr_count  out  ADDR_W+1  samples stored; saturates at DEPTH
- wrapped  out  1  circular mode only: at least one overwrite has occurred

Behaviour:
- Reset (sync, active-high): state=IDLE; wr_addr=0; skip_cnt=0; wr_count=0; wrapped=0; busy=0; done=0; rd_data=0. Memory contents are not cleared. Reset mid-capture aborts the capture immediately; no write occurs in the reset cycle.
- States: IDLE, SKIP, CAPTURE, DONE. busy and done are decoded from the registered state.
- IDLE:
  - start_sink clears wr_addr, wr_count, wrapped and skip_cnt.
  - Goes to SKIP, or directly to CAPTURE when SKIP=0.
  - stop is ignored. start_sink and stop in the same cycle: start wins.
- SKIP:
  - Each data_valid increments skip_cnt; no memory write.
  - A valid sample with skip_cnt==SKIP-1 goes to CAPTURE. The next valid sample is the first one stored.
  - stop goes to DONE with wr_count=0.
- CAPTURE, on each data_valid:
  - mem[wr_addr] <= data_in, written the same cycle.
  - wr_addr increments; wr_count increments, saturating at DEPTH.
  - Write at wr_addr==DEPTH-1 with CIRCULAR=0: go to DONE.
  - Write at wr_addr==DEPTH-1 with CIRCULAR=1: wr_addr wraps to 0 and wrapped is set on the following write.
  - DEPTH not a power of two: wrap is by compare, not by overflow.
- stop in CAPTURE: goes to DONE. If data_valid is also high that cycle, the sample is written first. stop on the same cycle as the final one-shot write yields DONE with wr_count=DEPTH.
- start_sink in SKIP or CAPTURE is ignored.
- DONE: holds all status. start_sink re-arms exactly as from IDLE and clears done on the next cycle.
- Read port:
  - Independent of state; rd_data <= mem[rd_addr] every cycle.
  - Read-during-write to the same address returns the old data.
  - rd_addr >= DEPTH returns undefined data; the bench must not check it.
- Widths: wr_count is ADDR_W+1 bits so that a value of DEPTH=2**ADDR_W is representable. skip_cnt width is clog2(SKIP+1), minimum 1.

Decomposition:
- Package capture_sink_pkg holds the state encoding constants (IDLE, SKIP, CAPTURE, DONE, 2-bit) and a clog2 helper function.
- One sub-module, sdp_ram (parameters DATA_W, ADDR_W, DEPTH):
  - one write port (we, waddr, wdata)
  - one registered read port (raddr, rdata) with old-data read-during-write
  - replaces the vendor ram instance and is inferable on FPGA block RAM.
- Control FSM and counters stay in capture_sink.

Test Plan:
- Defaults; start_sink, then data 0x00..0xFF with valid every cycle -> samples 0x00..0x04 skipped; mem[0]=0x05, mem[250]=0xFF; after data 0x00..0x04 reach addresses 251..255, done=1 and wr_count=256; further data is not written.
- Default config with SKIP=0; valid asserted every other cycle -> only valid samples stored, consecutively at addresses 0,1,2...; wr_count matches the number of valid pulses.
- stop after 10 stored samples, with valid high on the stop cycle -> 11 samples stored, done=1, wr_count=11, mem[11] unchanged.
- CIRCULAR=1, DEPTH=6 (non-power-of-two), SKIP=0; 8 samples 0x10..0x17 then stop -> mem[0]=0x16, mem[1]=0x17, mem[2..5]=0x12..0x15, wrapped=1, wr_count=6.
- reset asserted in the middle of CAPTURE -> next cycle busy=0, done=0, wr_count=0, no write in the reset cycle; a subsequent start_sink captures from address 0.
- Readback during capture at the address currently being written -> rd_data returns the old contents one cycle later; start_sink pulsed while busy -> no effect on wr_addr or skip_cnt.
